c2_adder_arbiter: RTL and testbench
===================================

// Module: c2_adder_arbiter
// PURPOSE
//  Shares one C2Adder (SIZE-bit, C2-cell ripple carry) between two requesters.
//  Each requester presents an operand pair on a valid/ready handshake.
//  A round-robin FSM grants one request at a time, latches its operands, drives
//  the shared adder and holds the (SIZE+1)-bit result until the consumer takes it.
//  Sits between the datapath clients and the single adder instance.
// PARAMETERS
//  SIZE   5   operand width; adder and sum path are SIZE / SIZE+1 bits
// PORTS
//  clk        in   1       rising-edge clock, the only clock
//  rst_n      in   1       asynchronous, active-low reset
//  in0_valid  in   1       requester 0 has an operand pair
//  in0_a      in   SIZE    requester 0 operand A
//  in0_b      in   SIZE    requester 0 operand B
//  in0_ready  out  1       requester 0 pair accepted this cycle
//  in1_valid  in   1       requester 1 has an operand pair
//  in1_a      in   SIZE    requester 1 operand A
//  in1_b      in   SIZE    requester 1 operand B
//  in1_ready  out  1       requester 1 pair accepted this cycle
//  out_valid  out  1       result available
//  out_sum    out  SIZE+1  {carry, sum} of the granted pair
//  out_id     out  1       requester index that owns out_sum
//  out_ready  in   1       consumer takes the result
//  busy       out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, rr_ptr=0, op regs=0, out_valid=0,
//   out_sum=0, out_id=0. Any in-flight transaction is dropped. Requesters re-present.
//  FSM: IDLE -> CALC -> RESP -> IDLE.
//   IDLE: if any inX_valid, the winner is chosen and its ready goes high.
//    On that edge: a/b are latched, the winner id is latched, rr_ptr <= ~winner,
//    and the FSM goes to CALC. With no valid it stays in IDLE.
//   CALC: the adder is fed only from the latched a/b, with carry-in 0.
//    At the edge: out_sum <= adder o, out_id <= latched id, out_valid <= 1, go to RESP.
//   RESP: out_valid=1, out_sum/out_id stable. Leave for IDLE at the edge where
//    out_ready=1 (out_valid <= 0). Otherwise hold indefinitely.
//  Handshake: inX_ready = (state==IDLE) & inX_valid & (winner==X). It is
//   combinational and never high in CALC/RESP.
//   Transfer happens when valid & ready. A requester holds valid and data until then.
//   Valid asserted during CALC/RESP simply waits; nothing is lost.
//  Arbitration: only one valid -> it wins. Both valid -> requester rr_ptr wins.
//   rr_ptr updates only on a grant, so continuous contention alternates 0,1,0,1...
//  Latency: accept at edge t -> out_valid high after edge t+1.
//   Best case, out_ready tied 1: one transaction per 3 cycles, no bypass.
//  Width: out_sum = a + b zero-extended to SIZE+1, no overflow possible.
//   Max 2^SIZE-1 + 2^SIZE-1 (0b111110 for SIZE=5).
//  Operand changes on inX_* after acceptance do not affect the result.
//  busy = (state != IDLE). out_ready while out_valid=0 is ignored.
// TESTING (SIZE=5)
//  1. in0 a=3,b=4 alone -> in0_ready 1 cycle. Two edges later out_valid=1, out_sum=7, out_id=0.
//  2. in1 a=31,b=1 -> out_sum=6'b100000, out_id=1. Then a=31,b=31 -> 6'b111110.
//  3. Both valid, held for 4 transactions after reset -> grant order 0,1,0,1.
//     Each sum is correct and tagged with the matching out_id.
//  4. out_ready held 0 for 10 cycles in RESP -> out_sum/out_id stable, both readies 0.
//     Raise out_ready -> one transfer, then IDLE.
//  5. Drop rst_n in CALC -> out_valid=0, busy=0, rr_ptr=0 immediately.
//     After release, the re-presented request completes normally.
//  6. Change in0_a the cycle after accept -> result uses the latched value.

Source files
------------

// File: rtl/c2_adder_arbiter.sv
// c2_adder_arbiter
// Two requesters share one SIZE-bit C2-cell ripple-carry adder. A round-robin
// IDLE -> CALC -> RESP FSM grants one operand pair at a time, latches it, adds it
// with carry-in 0, and holds the {carry, sum} result until the consumer takes it.
module c2_adder_arbiter #(
    parameter int SIZE = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in0_valid,
    input  logic [SIZE-1:0] in0_a,
    input  logic [SIZE-1:0] in0_b,
    output logic            in0_ready,
    input  logic            in1_valid,
    input  logic [SIZE-1:0] in1_a,
    input  logic [SIZE-1:0] in1_b,
    output logic            in1_ready,
    output logic            out_valid,
    output logic [SIZE:0]   out_sum,
    output logic            out_id,
    input  logic            out_ready,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // One C2 cell: {carry_out, sum_bit} of a single bit position.
    function automatic logic [1:0] c2_cell(input logic a, input logic b, input logic cin);
        logic s;
        logic co;
        s  = a ^ b ^ cin;
        co = (a & b) | (cin & (a ^ b));
        return {co, s};
    endfunction

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic            rr_ptr;
    logic            winner;
    logic            grant;

    logic [SIZE-1:0] a_p0;
    logic [SIZE-1:0] b_p0;
    logic            id_p0;

    logic [SIZE:0]   carry;
    logic [SIZE-1:0] sum_bits;
    logic [SIZE:0]   adder_o;

    logic [SIZE:0]   sum_p1;
    logic            id_p1;
    logic            vld_p1;

    // Pick the winner: a lone requester wins, contention goes to rr_ptr.
    always_comb begin
        winner = 1'b0;
        if (in0_valid && in1_valid) begin
            winner = rr_ptr;
        end else if (in1_valid) begin
            winner = 1'b1;
        end
    end

    assign grant     = (state == S_IDLE) && (in0_valid || in1_valid);
    assign in0_ready = grant && in0_valid && !winner;
    assign in1_ready = grant && in1_valid &&  winner;

    // Next-state logic of the IDLE -> CALC -> RESP sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant) state_nxt = S_CALC;
            S_CALC:  state_nxt = S_RESP;
            S_RESP:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control state: FSM register and round-robin pointer, moved only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                rr_ptr <= ~winner;
            end
        end
    end

    // ---- stage p0: operand latch at the grant edge ----
    // Capture the winning pair and its owner so later input changes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p0  <= '0;
            b_p0  <= '0;
            id_p0 <= 1'b0;
        end else if (grant) begin
            a_p0  <= winner ? in1_a : in0_a;
            b_p0  <= winner ? in1_b : in0_b;
            id_p0 <= winner;
        end
    end

    // Shared ripple-carry adder, fed only from the latched operands, carry-in 0.
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < SIZE; i++) begin : g_cell
        assign {carry[i+1], sum_bits[i]} = c2_cell(a_p0[i], b_p0[i], carry[i]);
    end
    assign adder_o = {carry[SIZE], sum_bits};

    // ---- stage p1: result register, loaded leaving CALC, held through RESP ----
    // Capture the sum in CALC and keep it until the consumer accepts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p1 <= '0;
            id_p1  <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            if (state == S_CALC) begin
                sum_p1 <= adder_o;
                id_p1  <= id_p0;
                vld_p1 <= 1'b1;
            end else if ((state == S_RESP) && out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_sum   = sum_p1;
    assign out_id    = id_p1;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_c2_adder_arbiter.sv
// Directed bench for c2_adder_arbiter (SIZE=5): vector table of single
// transactions plus hand sequences for contention, back-pressure, mid-flight
// reset and post-accept operand changes.
module tb_c2_adder_arbiter;

    localparam int SIZE = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in0_valid;
    logic [SIZE-1:0] in0_a;
    logic [SIZE-1:0] in0_b;
    logic            in0_ready;
    logic            in1_valid;
    logic [SIZE-1:0] in1_a;
    logic [SIZE-1:0] in1_b;
    logic            in1_ready;
    logic            out_valid;
    logic [SIZE:0]   out_sum;
    logic            out_id;
    logic            out_ready;
    logic            busy;

    int checks = 0;
    int errors = 0;

    c2_adder_arbiter #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_a     (in0_a),
        .in0_b     (in0_b),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_a     (in1_a),
        .in1_b     (in1_b),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_id    (out_id),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            v0;
        logic [SIZE-1:0] a0;
        logic [SIZE-1:0] b0;
        logic            v1;
        logic [SIZE-1:0] a1;
        logic [SIZE-1:0] b1;
        logic [SIZE:0]   sum;
        logic            id;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Starts at a negedge with the FSM idle; ends at a negedge with the FSM idle.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        in0_valid = v.v0; in0_a = v.a0; in0_b = v.b0;
        in1_valid = v.v1; in1_a = v.a1; in1_b = v.b1;
        #1;
        chk({tag, "_in0_ready"}, in0_ready, v.id == 1'b0);
        chk({tag, "_in1_ready"}, in1_ready, v.id == 1'b1);
        @(posedge clk); #1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        chk({tag, "_busy_calc"}, busy, 1);
        @(negedge clk);
        chk({tag, "_valid_calc"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid_resp"}, out_valid, 1);
        chk({tag, "_sum"}, out_sum, v.sum);
        chk({tag, "_id"}, out_id, v.id);
        @(posedge clk); #1;
        chk({tag, "_valid_done"}, out_valid, 0);
        chk({tag, "_busy_done"}, busy, 0);
        @(negedge clk);
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, out_valid, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        in0_valid = 1'b0; in0_a = '0; in0_b = '0;
        in1_valid = 1'b0; in1_a = '0; in1_b = '0;
        out_ready = 1'b1;

        // Sequential table: both-valid entries depend on rr_ptr history from reset.
        vecs[0] = '{1'b1, 5'd3,  5'd4,  1'b0, 5'd0,  5'd0,  6'd7,  1'b0};
        vecs[1] = '{1'b0, 5'd0,  5'd0,  1'b1, 5'd31, 5'd1,  6'd32, 1'b1};
        vecs[2] = '{1'b0, 5'd0,  5'd0,  1'b1, 5'd31, 5'd31, 6'd62, 1'b1};
        vecs[3] = '{1'b1, 5'd0,  5'd0,  1'b0, 5'd0,  5'd0,  6'd0,  1'b0};
        vecs[4] = '{1'b1, 5'd10, 5'd5,  1'b1, 5'd7,  5'd9,  6'd16, 1'b1};
        vecs[5] = '{1'b1, 5'd10, 5'd5,  1'b1, 5'd7,  5'd9,  6'd15, 1'b0};
        vecs[6] = '{1'b1, 5'd31, 5'd31, 1'b0, 5'd0,  5'd0,  6'd62, 1'b0};
        vecs[7] = '{1'b0, 5'd0,  5'd0,  1'b1, 5'd16, 5'd16, 6'd32, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Contention from a fresh reset: both held valid -> grants 0,1,0,1.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in0_valid = 1'b1; in0_a = 5'd1; in0_b = 5'd2;
        in1_valid = 1'b1; in1_a = 5'd4; in1_b = 5'd8;
        for (int i = 0; i < 4; i++) begin
            wait_out_valid($sformatf("rr%0d", i));
            chk($sformatf("rr%0d_id", i), out_id, i % 2);
            chk($sformatf("rr%0d_sum", i), out_sum, (i % 2 == 0) ? 3 : 12);
            @(negedge clk);
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rr_idle", busy, 0);

        // Back-pressure: result held for 10 cycles, no readies while waiting.
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_a = 5'd5; in0_b = 5'd6;
        @(posedge clk); #1;
        in0_valid = 1'b0;
        in1_valid = 1'b1; in1_a = 5'd2; in1_b = 5'd9;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold%0d_valid", i), out_valid, 1);
            chk($sformatf("hold%0d_sum", i), out_sum, 11);
            chk($sformatf("hold%0d_id", i), out_id, 0);
            chk($sformatf("hold%0d_r1", i), in1_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_valid", out_valid, 0);
        chk("hold_release_busy", busy, 0);
        chk("hold_next_r1", in1_ready, 1);
        @(posedge clk); #1;
        in1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("hold_next_sum", out_sum, 11);
        chk("hold_next_id", out_id, 1);
        @(posedge clk); #1;
        @(negedge clk);

        // Reset while in CALC after an in0 grant (rr_ptr would be 1).
        in0_valid = 1'b1; in0_a = 5'd9; in0_b = 5'd9;
        @(posedge clk); #1;
        in0_valid = 1'b0;
        chk("rstcalc_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rstcalc_valid", out_valid, 0);
        chk("rstcalc_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in0_valid = 1'b1; in0_a = 5'd9; in0_b = 5'd9;
        in1_valid = 1'b1; in1_a = 5'd1; in1_b = 5'd1;
        #1;
        chk("rstcalc_rr_r0", in0_ready, 1);
        chk("rstcalc_rr_r1", in1_ready, 0);
        @(posedge clk); #1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstcalc_sum", out_sum, 18);
        chk("rstcalc_id", out_id, 0);
        @(posedge clk); #1;
        @(negedge clk);

        // Operand changed right after acceptance must not affect the sum.
        in0_valid = 1'b1; in0_a = 5'd2; in0_b = 5'd3;
        @(posedge clk); #1;
        in0_a = 5'd20; in0_b = 5'd20;
        in0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("latch_valid", out_valid, 1);
        chk("latch_sum", out_sum, 5);
        @(posedge clk); #1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
